// File: rtl/adain_seq_ctrl.sv
// adain_seq_ctrl -- sequencer for one AdaIN channel pass.
//
// Runs three streaming passes over channel memory (SUM, VAR, NORM), with a
// fixed 4-step compute phase (MEAN, INVSQ) after each of the first two.
// It drives the phase code, sub-step index and enables consumed by the
// shift-amount generator, MAC accumulator and normalize pipeline, and it
// owns the output valid/ready handshake.
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   start, n_pixels begin a pass with N pixels (sampled in IDLE only)
//   abort           synchronous cancel of a running pass
//   rd_en, rd_addr  memory read strobe/address (1-cycle read latency)
//   acc_clr, acc_en accumulator clear / accumulate
//   state, l_count  phase code and MEAN/INVSQ sub-step index
//   en_shift        shift-amount register enable
//   pipe_en         normalize pipeline advance (combinational)
//   out_valid       normalized pixel available; out_ready = downstream accepts
//   busy, done, err status: not idle / completion pulse / rejected start
module adain_seq_ctrl #(
  parameter int N_MAX    = 128,
  parameter int WIDTH_N  = $clog2(N_MAX + 1),
  parameter int MAC_LAT  = 2,
  parameter int NORM_LAT = 3
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [WIDTH_N-1:0]        n_pixels,
  input  logic                      abort,
  output logic                      rd_en,
  output logic [$clog2(N_MAX)-1:0]  rd_addr,
  output logic                      acc_clr,
  output logic                      acc_en,
  output logic [2:0]                state,
  output logic [1:0]                l_count,
  output logic                      en_shift,
  output logic                      pipe_en,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic                      busy,
  output logic                      done,
  output logic                      err
);

  localparam int ADDR_W = $clog2(N_MAX);
  localparam int DW     = $clog2(MAC_LAT + 1);
  localparam logic [WIDTH_N-1:0] N_MAX_W = WIDTH_N'(N_MAX);
  localparam logic [DW-1:0]      DRAIN_LAST = DW'(MAC_LAT - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'b000,
    S_SUM   = 3'b001,
    S_MEAN  = 3'b010,
    S_INVSQ = 3'b011,
    S_VAR   = 3'b101,
    S_NORM  = 3'b110,
    S_DONE  = 3'b111
  } state_t;

  state_t              cur, nxt;
  logic [ADDR_W-1:0]   n_last, next_n_last;   // N-1, terminal address/count
  logic [ADDR_W-1:0]   xfer, next_xfer;       // completed NORM transfers
  logic [DW-1:0]       drain, next_drain;     // MAC drain cycles elapsed
  logic [ADDR_W-1:0]   next_addr;
  logic [1:0]          next_l;
  logic                next_rd_en, next_acc_clr, next_acc_en, next_en_shift;
  logic                next_done, next_err;
  logic [NORM_LAT-1:0] vpipe;                 // valid tokens in the normalize pipe
  logic                flush;

  assign state     = cur;
  assign out_valid = vpipe[NORM_LAT-1];
  assign pipe_en   = !(out_valid && !out_ready);
  assign flush     = abort && (cur != S_IDLE);

  always_comb begin
    nxt           = cur;
    next_n_last   = n_last;
    next_xfer     = xfer;
    next_drain    = drain;
    next_addr     = rd_addr;
    next_l        = 2'd0;
    next_rd_en    = 1'b0;
    next_acc_clr  = 1'b0;
    next_acc_en   = rd_en && pipe_en;
    next_en_shift = 1'b0;
    next_done     = 1'b0;
    next_err      = 1'b0;

    if (flush) begin
      nxt         = S_IDLE;
      next_addr   = '0;
      next_xfer   = '0;
      next_drain  = '0;
      next_acc_en = 1'b0;
    end else begin
      unique case (cur)
        S_IDLE: begin
          if (start) begin
            if (n_pixels == '0 || n_pixels > N_MAX_W) begin
              next_err = 1'b1;
            end else begin
              nxt          = S_SUM;
              next_n_last  = ADDR_W'(n_pixels - WIDTH_N'(1));
              next_addr    = '0;
              next_rd_en   = 1'b1;
              next_acc_clr = 1'b1;
              next_drain   = '0;
            end
          end
        end

        // rd_en low inside SUM/VAR marks the MAC drain tail.
        S_SUM, S_VAR: begin
          if (rd_en) begin
            if (rd_addr != n_last) begin
              next_rd_en = 1'b1;
              next_addr  = rd_addr + ADDR_W'(1);
            end
          end else if (drain == DRAIN_LAST) begin
            next_drain    = '0;
            nxt           = (cur == S_SUM) ? S_MEAN : S_INVSQ;
            next_en_shift = 1'b1;
          end else begin
            next_drain = drain + DW'(1);
          end
        end

        S_MEAN, S_INVSQ: begin
          if (l_count == 2'd3) begin
            next_addr  = '0;
            next_rd_en = 1'b1;
            if (cur == S_MEAN) begin
              nxt          = S_VAR;
              next_acc_clr = 1'b1;
            end else begin
              nxt       = S_NORM;
              next_xfer = '0;
            end
          end else begin
            next_l        = l_count + 2'd1;
            next_en_shift = 1'b1;
          end
        end

        S_NORM: begin
          next_rd_en = rd_en;
          if (pipe_en && rd_en) begin
            if (rd_addr == n_last) next_rd_en = 1'b0;
            else                   next_addr  = rd_addr + ADDR_W'(1);
          end
          if (out_valid && out_ready) begin
            if (xfer == n_last) begin
              nxt        = S_DONE;
              next_done  = 1'b1;
              next_rd_en = 1'b0;
            end else begin
              next_xfer = xfer + ADDR_W'(1);
            end
          end
        end

        S_DONE: nxt = S_IDLE;

        default: nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cur      <= S_IDLE;
      n_last   <= '0;
      xfer     <= '0;
      drain    <= '0;
      rd_addr  <= '0;
      l_count  <= 2'd0;
      rd_en    <= 1'b0;
      acc_clr  <= 1'b0;
      acc_en   <= 1'b0;
      en_shift <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
    end else begin
      cur      <= nxt;
      n_last   <= next_n_last;
      xfer     <= next_xfer;
      drain    <= next_drain;
      rd_addr  <= next_addr;
      l_count  <= next_l;
      rd_en    <= next_rd_en;
      acc_clr  <= next_acc_clr;
      acc_en   <= next_acc_en;
      en_shift <= next_en_shift;
      busy     <= (nxt != S_IDLE);
      done     <= next_done;
      err      <= next_err;
    end
  end

  // Only NORM reads enter the valid pipe; the whole pipe freezes on stall.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      vpipe <= '0;
    end else if (pipe_en) begin
      vpipe <= (vpipe << 1) | NORM_LAT'(rd_en && (cur == S_NORM));
    end
  end

endmodule

// File: tb/tb_adain_seq_ctrl.sv
// tb_adain_seq_ctrl -- scoreboard bench for adain_seq_ctrl.
// Expected read addresses, MEAN/INVSQ sub-steps and accumulator clears are
// queued when a pass is started and popped as the DUT produces them.
module tb_adain_seq_ctrl;
  localparam int N_MAX    = 128;
  localparam int WIDTH_N  = 8;
  localparam int MAC_LAT  = 2;
  localparam int NORM_LAT = 3;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               start = 1'b0;
  logic [WIDTH_N-1:0] n_pixels = '0;
  logic               abort = 1'b0;
  logic               out_ready = 1'b1;
  logic               rd_en, acc_clr, acc_en, en_shift, pipe_en, out_valid;
  logic               busy, done, err;
  logic [6:0]         rd_addr;
  logic [2:0]         state;
  logic [1:0]         l_count;

  adain_seq_ctrl #(.N_MAX(N_MAX), .WIDTH_N(WIDTH_N), .MAC_LAT(MAC_LAT),
                   .NORM_LAT(NORM_LAT)) dut (
    .clk(clk), .rst(rst), .start(start), .n_pixels(n_pixels), .abort(abort),
    .rd_en(rd_en), .rd_addr(rd_addr), .acc_clr(acc_clr), .acc_en(acc_en),
    .state(state), .l_count(l_count), .en_shift(en_shift), .pipe_en(pipe_en),
    .out_valid(out_valid), .out_ready(out_ready), .busy(busy), .done(done),
    .err(err)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int unsigned n_vec = 0, n_err = 0;

  task automatic check(input string tag, input int unsigned got, input int unsigned exp);
    n_vec++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  typedef struct { int unsigned st; int unsigned addr; } rd_t;
  typedef struct { int unsigned cyc; int unsigned lc; } lc_t;
  rd_t         exp_rd[$];
  lc_t         exp_lc[$];
  int unsigned exp_clr[$];

  bit          mon_on = 1'b0, prev_issue = 1'b0;
  int unsigned t0 = 0, beats = 0, done_seen = 0, done_rel = 0, max_addr = 0;
  int unsigned n_extra = 0;

  always @(negedge clk) begin
    int unsigned rel;
    rd_t r;
    lc_t l;
    if (mon_on) begin
      rel = cyc - t0;
      check("busy", busy, state != 3'd0);
      check("acc_en", acc_en, prev_issue);
      if (rd_en && pipe_en) begin
        if (exp_rd.size() == 0) n_extra++;
        else begin
          r = exp_rd.pop_front();
          check("rd_state", state, r.st);
          check("rd_addr", rd_addr, r.addr);
        end
        if (rd_addr > max_addr) max_addr = rd_addr;
      end
      if (state == 3'b010 || state == 3'b011) begin
        if (exp_lc.size() == 0) n_extra++;
        else begin
          l = exp_lc.pop_front();
          check("lc_cycle", rel, l.cyc);
          check("l_count", l_count, l.lc);
          check("en_shift", en_shift, 1);
        end
      end else begin
        check("l_count_other", l_count, 0);
        check("en_shift_other", en_shift, 0);
      end
      if (acc_clr) begin
        if (exp_clr.size() == 0) n_extra++;
        else check("clr_cycle", rel, exp_clr.pop_front());
      end
      if (out_valid && out_ready) beats++;
      if (done) begin
        done_seen++;
        done_rel = rel;
      end
    end
    prev_issue = rd_en && pipe_en;
  end

  task automatic expect_pass(input int unsigned n);
    int unsigned m0, i0;
    rd_t r;
    lc_t l;
    foreach (exp_rd[k]) ;
    for (int unsigned p = 0; p < 3; p++)
      for (int unsigned a = 0; a < n; a++) begin
        r.st   = (p == 0) ? 1 : (p == 1) ? 5 : 6;
        r.addr = a;
        exp_rd.push_back(r);
      end
    m0 = 1 + n + MAC_LAT;
    i0 = m0 + 4 + n + MAC_LAT;
    for (int unsigned k = 0; k < 8; k++) begin
      l.cyc = (k < 4) ? m0 + k : i0 + k - 4;
      l.lc  = k % 4;
      exp_lc.push_back(l);
    end
    exp_clr.push_back(1);
    exp_clr.push_back(m0 + 4);
  endtask

  task automatic begin_pass(input int unsigned n);
    expect_pass(n);
    start = 1'b1;
    n_pixels = WIDTH_N'(n);
    t0 = cyc;
    beats = 0; done_seen = 0; done_rel = 0; max_addr = 0; n_extra = 0;
    mon_on = 1'b1;
  endtask

  task automatic clear_sb();
    mon_on = 1'b0;
    exp_rd.delete();
    exp_lc.delete();
    exp_clr.delete();
  endtask

  // Caller is #1 after a posedge; start is driven in that cycle.
  task automatic run_pass(input int unsigned n, input bit stall);
    int unsigned exp_done, rel, budget;
    exp_done = 3 * n + 2 * MAC_LAT + 9 + NORM_LAT + (stall ? 3 : 0);
    budget = exp_done + 20;
    begin_pass(n);
    for (int unsigned i = 0; i < budget && done_seen == 0; i++) begin
      @(posedge clk); #1;
      rel = cyc - t0;
      start = 1'b0;
      n_pixels = WIDTH_N'(n);
      if (rel == 5) begin
        start = 1'b1;
        n_pixels = WIDTH_N'(2);
      end
      out_ready = !(stall && rel >= 25 && rel <= 27);
    end
    out_ready = 1'b1;
    check("done_cycle", done_rel, exp_done);
    check("done_pulses", done_seen, 1);
    check("beats", beats, n);
    check("max_addr", max_addr, n - 1);
    check("rd_left", exp_rd.size(), 0);
    check("lc_left", exp_lc.size(), 0);
    check("clr_left", exp_clr.size(), 0);
    check("extras", n_extra, 0);
    check("idle_after", state, 0);
    check("busy_after", busy, 0);
    clear_sb();
  endtask

  task automatic err_case(input int unsigned n);
    @(posedge clk); #1;
    start = 1'b1;
    n_pixels = WIDTH_N'(n);
    @(posedge clk); #1;
    start = 1'b0;
    check("err_pulse", err, 1);
    check("err_busy", busy, 0);
    check("err_state", state, 0);
    @(posedge clk); #1;
    check("err_clear", err, 0);
    check("err_state2", state, 0);
  endtask

  task automatic abort_case();
    int unsigned rel;
    bit hit;
    hit = 1'b0;
    begin_pass(4);
    for (int unsigned i = 0; i < 40 && !hit; i++) begin
      @(posedge clk); #1;
      rel = cyc - t0;
      start = 1'b0;
      if (rel == 19) begin
        abort = 1'b1;
        hit = 1'b1;
      end
    end
    @(posedge clk); #1;
    abort = 1'b0;
    check("abort_state", state, 0);
    check("abort_lc", l_count, 0);
    check("abort_en_shift", en_shift, 0);
    check("abort_busy", busy, 0);
    check("abort_rd_en", rd_en, 0);
    check("abort_valid", out_valid, 0);
    repeat (30) @(posedge clk);
    #1;
    check("abort_no_done", done_seen, 0);
    clear_sb();
    run_pass(4, 1'b0);
  endtask

  task automatic rst_case();
    begin_pass(4);
    for (int unsigned i = 0; i < 40 && !out_valid; i++) begin
      @(posedge clk); #1;
      start = 1'b0;
    end
    check("valid_before_rst", out_valid, 1);
    check("norm_before_rst", state, 3'b110);
    clear_sb();
    rst = 1'b1;
    start = 1'b1;
    n_pixels = WIDTH_N'(3);
    @(posedge clk); #1;
    rst = 1'b0;
    start = 1'b0;
    check("rst_state", state, 0);
    check("rst_lc", l_count, 0);
    check("rst_addr", rd_addr, 0);
    check("rst_rd_en", rd_en, 0);
    check("rst_acc_clr", acc_clr, 0);
    check("rst_acc_en", acc_en, 0);
    check("rst_en_shift", en_shift, 0);
    check("rst_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check("rst_pipe_en", pipe_en, 1);
    @(posedge clk); #1;
    check("rst_start_ignored", state, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish, required finish before time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("reset_state", state, 0);
    check("reset_busy", busy, 0);
    check("reset_rd_en", rd_en, 0);
    check("reset_valid", out_valid, 0);
    check("reset_pipe_en", pipe_en, 1);
    rst = 1'b0;
    @(posedge clk); #1;
    run_pass(4, 1'b0);
    run_pass(4, 1'b0);      // back-to-back: start in the IDLE cycle after DONE
    run_pass(4, 1'b1);
    err_case(0);
    err_case(129);
    @(posedge clk); #1;
    run_pass(128, 1'b0);
    abort_case();
    rst_case();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
